// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusyIf,
    StBusyDm,
    StResp
  } arb_state_e;

  typedef enum logic {
    SRC_IF,
    SRC_DM
  } arb_src_e;

  localparam int unsigned DefaultTimeout = 255;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Busy-cycle counter for the arbiter; flags the last allowed busy cycle.
module arb_timeout_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_busy,
  output logic o_expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Held at zero outside busy, so every access starts counting from zero.
  always_comb begin
    cnt_d = '0;
    if (i_busy) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expired = i_busy && (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between fetch and data ports, data first; stalls the pipeline meanwhile.
// Optional busy timeout abort is enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_ack,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_dm_req,
  input  logic                i_dm_we,
  input  logic [DATA_W/8-1:0] i_dm_wstrb,
  input  logic [ADDR_W-1:0]   i_dm_addr,
  input  logic [DATA_W-1:0]   i_dm_wdata,
  output logic                o_dm_ack,
  output logic [DATA_W-1:0]   o_dm_rdata,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [DATA_W/8-1:0] o_mem_wstrb,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  input  logic                i_mem_ack,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_stall,
  output logic                o_bus_err
);

  localparam int unsigned StrbW = DATA_W / 8;

  arb_state_e state_q, state_d;
  arb_src_e   grant;

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [StrbW-1:0]  mem_wstrb_q, mem_wstrb_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              bus_err_q, bus_err_d;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;
  logic              timeout_hit;

  assign busy = (state_q == StBusyIf) || (state_q == StBusyDm);

`ifdef ARB_TIMEOUT_EN
  arb_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_ctr (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_busy   (busy),
    .o_expired(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    grant       = i_dm_req ? SRC_DM : SRC_IF;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    bus_err_d   = 1'b0;
    // Stores and aborted accesses return zero.
    rsp_data    = (i_mem_ack && !mem_we_q) ? i_mem_rdata : '0;

    unique case (state_q)
      StIdle: begin
        if (i_dm_req || i_if_req) begin
          mem_req_d = 1'b1;
          if (grant == SRC_DM) begin
            state_d     = StBusyDm;
            mem_we_d    = i_dm_we;
            mem_wstrb_d = i_dm_wstrb;
            mem_addr_d  = i_dm_addr;
            mem_wdata_d = i_dm_wdata;
          end else begin
            state_d     = StBusyIf;
            mem_we_d    = 1'b0;
            mem_wstrb_d = '0;
            mem_addr_d  = i_if_addr;
            mem_wdata_d = '0;
          end
        end
      end
      StBusyIf, StBusyDm: begin
        if (i_mem_ack || timeout_hit) begin
          state_d   = StResp;
          mem_req_d = 1'b0;
          bus_err_d = !i_mem_ack;
          if (state_q == StBusyDm) begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = rsp_data;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = rsp_data;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wstrb_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_wstrb = mem_wstrb_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_if_ack    = if_ack_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_dm_ack    = dm_ack_q;
  assign o_dm_rdata  = dm_rdata_q;
  assign o_bus_err   = bus_err_q;

  assign o_stall = (i_if_req & ~if_ack_q) | (i_dm_req & ~dm_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction model compared every cycle plus directed literal checks.
module tb_mem_port_arbiter;

  localparam int TO = 8;
  localparam bit TimeoutOn =
`ifdef ARB_TIMEOUT_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_ack;
  logic [31:0] o_if_rdata;
  logic        i_dm_req;
  logic        i_dm_we;
  logic [3:0]  i_dm_wstrb;
  logic [31:0] i_dm_addr;
  logic [31:0] i_dm_wdata;
  logic        o_dm_ack;
  logic [31:0] o_dm_rdata;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [3:0]  o_mem_wstrb;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_stall;
  logic        o_bus_err;

  mem_port_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TO)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_if_req   (i_if_req),
    .i_if_addr  (i_if_addr),
    .o_if_ack   (o_if_ack),
    .o_if_rdata (o_if_rdata),
    .i_dm_req   (i_dm_req),
    .i_dm_we    (i_dm_we),
    .i_dm_wstrb (i_dm_wstrb),
    .i_dm_addr  (i_dm_addr),
    .i_dm_wdata (i_dm_wdata),
    .o_dm_ack   (o_dm_ack),
    .o_dm_rdata (o_dm_rdata),
    .o_mem_req  (o_mem_req),
    .o_mem_we   (o_mem_we),
    .o_mem_wstrb(o_mem_wstrb),
    .o_mem_addr (o_mem_addr),
    .o_mem_wdata(o_mem_wdata),
    .i_mem_ack  (i_mem_ack),
    .i_mem_rdata(i_mem_rdata),
    .o_stall    (o_stall),
    .o_bus_err  (o_bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory bus responder: acks after mem_lat wait cycles; stray drives ack while idle.
  int mem_lat = 0;
  bit mute    = 1'b0;
  bit stray   = 1'b0;
  int wait_n  = 0;

  initial begin
    i_mem_ack   = 1'b0;
    i_mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        i_mem_ack = 1'b0;
        wait_n    = 0;
      end else if (o_mem_req && !mute) begin
        if (wait_n >= mem_lat) begin
          i_mem_ack   = 1'b1;
          i_mem_rdata = mem_word(o_mem_addr);
          wait_n      = 0;
        end else begin
          i_mem_ack = 1'b0;
          wait_n++;
        end
      end else begin
        i_mem_ack   = stray && !o_mem_req;
        i_mem_rdata = 32'hBAD0_BAD0;
        wait_n      = 0;
      end
    end
  end

  // Transaction model: one access in flight (1 = fetch, 2 = data), then a response cycle.
  int          m_busy, m_resp, m_cnt;
  logic        m_we;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
  logic        m_if_ack, m_dm_ack, m_err;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 0; m_resp <= 0; m_cnt <= 0;
      m_we <= 1'b0; m_wstrb <= '0; m_addr <= '0; m_wdata <= '0;
      m_if_rdata <= '0; m_dm_rdata <= '0;
      m_if_ack <= 1'b0; m_dm_ack <= 1'b0; m_err <= 1'b0;
    end else begin
      m_if_ack <= 1'b0;
      m_dm_ack <= 1'b0;
      m_err    <= 1'b0;
      if (m_resp != 0) begin
        m_resp <= 0;
      end else if (m_busy != 0) begin
        if (i_mem_ack || (TimeoutOn && (m_cnt + 1 >= TO))) begin
          m_resp <= m_busy;
          m_busy <= 0;
          m_err  <= !i_mem_ack;
          if (m_busy == 2) begin
            m_dm_ack   <= 1'b1;
            m_dm_rdata <= (i_mem_ack && !m_we) ? i_mem_rdata : 32'h0;
          end else begin
            m_if_ack   <= 1'b1;
            m_if_rdata <= i_mem_ack ? i_mem_rdata : 32'h0;
          end
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end else if (i_dm_req) begin
        m_busy <= 2; m_cnt <= 0;
        m_we <= i_dm_we; m_wstrb <= i_dm_wstrb; m_addr <= i_dm_addr; m_wdata <= i_dm_wdata;
      end else if (i_if_req) begin
        m_busy <= 1; m_cnt <= 0;
        m_we <= 1'b0; m_wstrb <= '0; m_addr <= i_if_addr;
      end
    end
  end

  always @(negedge clk) begin
    chk("mem_req", o_mem_req, m_busy != 0);
    if (m_busy != 0) begin
      chk("mem_addr", o_mem_addr, m_addr);
      chk("mem_we", o_mem_we, m_we);
      chk("mem_wstrb", o_mem_wstrb, m_wstrb);
      if (m_we) chk("mem_wdata", o_mem_wdata, m_wdata);
    end
    chk("if_ack", o_if_ack, m_if_ack);
    chk("dm_ack", o_dm_ack, m_dm_ack);
    chk("if_rdata", o_if_rdata, m_if_rdata);
    chk("dm_rdata", o_dm_rdata, m_dm_rdata);
    chk("bus_err", o_bus_err, m_err);
    chk("stall", o_stall, (i_if_req & ~m_if_ack) | (i_dm_req & ~m_dm_ack));
  end

  // Requesters: raise now, hold until ack, drop at the end of the ack cycle.
  task automatic if_access(input logic [31:0] a);
    int n;
    i_if_req  = 1'b1;
    i_if_addr = a;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      if (o_if_ack) break;
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL if_ack_wait actual=none required=ack addr=0x%0h", a);
      i_if_req = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      i_if_req = 1'b0;
    end
  endtask

  task automatic dm_access(input logic we, input logic [3:0] strb, input logic [31:0] a,
                           input logic [31:0] d);
    int n;
    i_dm_req   = 1'b1;
    i_dm_we    = we;
    i_dm_wstrb = strb;
    i_dm_addr  = a;
    i_dm_wdata = d;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      if (o_dm_ack) break;
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL dm_ack_wait actual=none required=ack addr=0x%0h", a);
      i_dm_req = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      i_dm_req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_n;
    rst = 1'b0;
    i_if_req = 1'b0; i_if_addr = '0;
    i_dm_req = 1'b0; i_dm_we = 1'b0; i_dm_wstrb = '0; i_dm_addr = '0; i_dm_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_req", o_mem_req, 1'b0);
    chk("reset_acks", {o_if_ack, o_dm_ack, o_bus_err}, 3'b000);
    chk("reset_stall", o_stall, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Lone fetch
    @(posedge clk);
    #1;
    i_if_req = 1'b1; i_if_addr = 32'h100;
    @(negedge clk);
    chk("lone_c0_stall", o_stall, 1'b1);
    @(negedge clk);
    chk("lone_c1_req", {o_mem_req, o_mem_we}, 2'b10);
    chk("lone_c1_addr", o_mem_addr, 32'h100);
    chk("lone_c1_stall", o_stall, 1'b1);
    @(negedge clk);
    chk("lone_c2_ack", o_if_ack, 1'b1);
    chk("lone_c2_rdata", o_if_rdata, 32'h0050_0093);
    chk("lone_c2_stall", o_stall, 1'b0);
    @(posedge clk);
    #1 i_if_req = 1'b0;

    // Simultaneous store and fetch
    @(posedge clk);
    #1;
    fork
      dm_access(1'b1, 4'hF, 32'h2000, 32'hDEAD_BEEF);
      if_access(32'h104);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("simul_c1_store", {o_mem_req, o_mem_we}, 2'b11);
        chk("simul_c1_addr", o_mem_addr, 32'h2000);
        chk("simul_c1_wdata", o_mem_wdata, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("simul_c2_acks", {o_dm_ack, o_if_ack}, 2'b10);
        chk("simul_c2_dm_rdata", o_dm_rdata, 32'h0);
        @(negedge clk);
        chk("simul_c3_idle", o_mem_req, 1'b0);
        @(negedge clk);
        chk("simul_c4_fetch", {o_mem_req, o_mem_we}, 2'b10);
        chk("simul_c4_addr", o_mem_addr, 32'h104);
        @(negedge clk);
        chk("simul_c5_if_ack", o_if_ack, 1'b1);
        chk("simul_c5_rdata", o_if_rdata, 32'h0104_FEFB);
      end
    join

    // Slow memory, then stray acks in idle
    mem_lat = 5;
    @(posedge clk);
    #1;
    fork
      dm_access(1'b0, 4'h0, 32'h40, 32'h0);
      begin
        busy_n = 0;
        repeat (12) @(negedge clk) if (o_mem_req) busy_n++;
        chk("slow_busy_cycles", busy_n, 6);
      end
    join
    mem_lat = 0;
    @(posedge clk);
    #1 stray = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stray_no_ack", {o_mem_req, o_if_ack, o_dm_ack}, 3'b000);
    end
    stray = 1'b0;
    @(posedge clk);

    // Byte store
    @(posedge clk);
    #1;
    fork
      dm_access(1'b1, 4'h2, 32'h3001, 32'h0000_AB00);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("byte_wstrb", o_mem_wstrb, 4'h2);
        chk("byte_addr", o_mem_addr, 32'h3001);
      end
    join

    // Mixed traffic at varying latency
    for (int i = 0; i < 4; i++) begin
      mem_lat = i;
      @(posedge clk);
      #1;
      fork
        if_access(32'h200 + 32'(i * 4));
        if (i % 2 == 1) dm_access(1'b0, 4'h0, 32'h800 + 32'(i * 4), 32'h0);
      join
    end
    mem_lat = 2;
    @(posedge clk);
    #1;
    fork
      if_access(32'h300);
      begin
        @(posedge clk);
        #1;
        dm_access(1'b0, 4'h0, 32'h400, 32'h0);
      end
    join
    mem_lat = 0;

    // Reset mid-transaction
    mem_lat = 20;
    @(posedge clk);
    #1;
    i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 32'h500;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy_before", o_mem_req, 1'b1);
    #2 rst = 1'b0;
    #1 chk("rst_async_mem_req", o_mem_req, 1'b0);
    i_dm_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    mem_lat = 0;
    repeat (4) begin
      @(negedge clk);
      chk("rst_after_quiet", {o_mem_req, o_dm_ack, o_if_ack}, 3'b000);
    end

`ifdef ARB_TIMEOUT_EN
    // Timeout abort
    mute = 1'b1;
    @(posedge clk);
    #1;
    fork
      dm_access(1'b0, 4'h0, 32'h600, 32'h0);
      begin
        busy_n = 0;
        repeat (9) @(negedge clk) if (o_mem_req) busy_n++;
        chk("to_busy_cycles", busy_n, TO);
        @(negedge clk);
        chk("to_ack_err", {o_dm_ack, o_bus_err}, 2'b11);
        chk("to_rdata", o_dm_rdata, 32'h0);
        @(negedge clk);
        chk("to_pulse_end", {o_dm_ack, o_bus_err}, 2'b00);
      end
    join
    mute = 1'b0;
    stray = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("to_late_ack", {o_dm_ack, o_if_ack}, 2'b00);
    end
    stray = 1'b0;
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
